mem_stage_v2: RTL and testbench

Parametrised successor of the pipeline MEMORY stage. Sits between the EX/MEM and MEM/WB pipeline registers. Adds:
- byte-addressed sub-word loads/stores (byte, halfword, word, signed/unsigned);
- a configurable-latency data memory with a stall handshake toward the upstream pipeline;
- misalignment detection.

ALU results that do not touch memory pass through in one cycle, as before.

---
 rtl/mem_stage_v2.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage_v2.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_v2.sv
// Pipeline MEMORY stage: byte-addressed sub-word loads/stores against a local data RAM,
// optional multi-cycle access with a stall handshake, and misalignment suppression.
module mem_stage_v2 #(
  parameter int DEPTH   = 128,
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_RT,
  input  logic [4:0]  XM_RD,
  input  logic        XM_MemToReg,
  input  logic        XM_MemWrite,
  input  logic [1:0]  XM_Size,
  input  logic        XM_Unsigned,
  input  logic        bnoWB,
  output logic [31:0] MW_ALUout,
  output logic [4:0]  MW_RD,
  output logic        MW_Misalign,
  output logic        mem_stall
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         LAT_ZERO = (MEM_LAT == 0);
  localparam logic [3:0] LAT_M1   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [31:0]      ram_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      alu_q, alu_d;
  logic [4:0]       rd_q, rd_d;
  logic             mis_q, mis_d;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic             req_s;
  logic             is_load_s;
  logic             is_store_s;
  logic             misalign_s;
  logic             aligned_req_s;
  logic             access_s;
  logic             stall_s;
  logic             ram_we_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      ram_d;
  logic             unused_addr_s;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] rt,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] res;
    case (size)
      2'b00:   wdata = {4{rt[7:0]}};
      2'b01:   wdata = {2{rt[15:0]}};
      default: wdata = rt;
    endcase
    be = lane_enables(size, lane);
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Address upper bits beyond the RAM index wrap around and are intentionally ignored.
  assign unused_addr_s = ^ALUout[31:IDX_W+2];
  assign idx_s         = ALUout[IDX_W+1:2];
  assign lane_s        = ALUout[1:0];
  assign req_s         = XM_MemToReg | XM_MemWrite;
  assign is_load_s     = XM_MemToReg;
  assign is_store_s    = XM_MemWrite & ~XM_MemToReg;
  assign aligned_req_s = req_s & ~misalign_s;
  assign rd_word_s     = ram_q[idx_s];
  assign ram_d         = merge_store(rd_word_s, XM_RT, XM_Size, lane_s);
  assign ram_we_s      = access_s & is_store_s & rst;
  assign mem_stall     = stall_s & rst;

  // Alignment check per access size
  always_comb begin
    misalign_s = 1'b0;
    case (XM_Size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = lane_s[0];
      default: misalign_s = (lane_s != 2'b00);
    endcase
  end

  // Cycle on which the memory operation actually takes effect
  always_comb begin
    access_s = 1'b0;
    if (LAT_ZERO) begin
      access_s = aligned_req_s;
    end else begin
      access_s = aligned_req_s && (state_q == S_DONE);
    end
  end

  // Latency FSM: IDLE accepts, BUSY counts down, DONE performs the access without stalling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aligned_req_s && !LAT_ZERO) begin
          stall_s = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? S_DONE : S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Next MEM/WB register contents; a stall injects a bubble and holds the data value
  always_comb begin
    alu_d = alu_q;
    rd_d  = 5'd0;
    mis_d = 1'b0;
    if (stall_s) begin
      alu_d = alu_q;
      rd_d  = 5'd0;
    end else if (req_s && misalign_s) begin
      alu_d = 32'd0;
      rd_d  = 5'd0;
      mis_d = 1'b1;
    end else if (is_store_s) begin
      alu_d = ALUout;
      rd_d  = 5'd0;
    end else if (is_load_s) begin
      alu_d = extract_load(rd_word_s, XM_Size, lane_s, XM_Unsigned);
      rd_d  = bnoWB ? 5'd0 : XM_RD;
    end else begin
      alu_d = ALUout;
      rd_d  = bnoWB ? 5'd0 : XM_RD;
    end
  end

  // Pipeline and FSM registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      alu_q   <= 32'd0;
      rd_q    <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
    end
  end

  // Data RAM: not reset, contents undefined at power-up
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[idx_s] <= ram_d;
    end
  end

  assign MW_ALUout   = alu_q;
  assign MW_RD       = rd_q;
  assign MW_Misalign = mis_q;

endmodule

// File: tb/tb_mem_stage_v2.sv
// Directed bench for mem_stage_v2: a zero-latency and a three-cycle-latency instance share stimulus.
module tb_mem_stage_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in;
  logic [31:0] rt_in;
  logic [4:0]  rd_in;
  logic        ld_in;
  logic        st_in;
  logic [1:0]  sz_in;
  logic        uns_in;
  logic        nowb_in;

  logic [31:0] m0_alu, m3_alu;
  logic [4:0]  m0_rd, m3_rd;
  logic        m0_mis, m3_mis;
  logic        m0_stall, m3_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_v2 #(.DEPTH(128), .MEM_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .ALUout(alu_in), .XM_RT(rt_in), .XM_RD(rd_in),
    .XM_MemToReg(ld_in), .XM_MemWrite(st_in), .XM_Size(sz_in), .XM_Unsigned(uns_in),
    .bnoWB(nowb_in), .MW_ALUout(m0_alu), .MW_RD(m0_rd), .MW_Misalign(m0_mis), .mem_stall(m0_stall)
  );

  mem_stage_v2 #(.DEPTH(128), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .ALUout(alu_in), .XM_RT(rt_in), .XM_RD(rd_in),
    .XM_MemToReg(ld_in), .XM_MemWrite(st_in), .XM_Size(sz_in), .XM_Unsigned(uns_in),
    .bnoWB(nowb_in), .MW_ALUout(m3_alu), .MW_RD(m3_rd), .MW_Misalign(m3_mis), .mem_stall(m3_stall)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] rt, input logic [4:0] rd,
                       input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic nowb);
    alu_in = a; rt_in = rt; rd_in = rd; ld_in = ld; st_in = st;
    sz_in = sz; uns_in = uns; nowb_in = nowb;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #12;
    total++; if (m0_alu !== 32'd0) begin bad++; $display("FAIL rst_alu0 got=%h exp=%h", m0_alu, 32'd0); end
    total++; if (m0_rd !== 5'd0) begin bad++; $display("FAIL rst_rd0 got=%0d exp=0", m0_rd); end
    total++; if (m0_mis !== 1'b0) begin bad++; $display("FAIL rst_mis0 got=%b exp=0", m0_mis); end
    total++; if (m3_alu !== 32'd0) begin bad++; $display("FAIL rst_alu3 got=%h exp=%h", m3_alu, 32'd0); end
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL rst_rd3 got=%0d exp=0", m3_rd); end
    drive(32'h40, 32'd0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL rst_stall3 got=%b exp=0", m3_stall); end
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_word();
    drive(32'h10, 32'hDEADBEEF, 5'd6, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m0_stall !== 1'b0) begin bad++; $display("FAIL sw_stall0 got=%b exp=0", m0_stall); end
    tick();
    total++; if (m0_rd !== 5'd0) begin bad++; $display("FAIL sw_rd got=%0d exp=0", m0_rd); end
    drive(32'h10, 32'd0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_alu got=%h exp=%h", m0_alu, 32'hDEADBEEF); end
    total++; if (m0_rd !== 5'd5) begin bad++; $display("FAIL lw_rd got=%0d exp=5", m0_rd); end
  endtask

  task automatic test_byte();
    drive(32'h13, 32'h00000080, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    drive(32'h13, 32'd0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_alu got=%h exp=%h", m0_alu, 32'hFFFFFF80); end
    total++; if (m0_rd !== 5'd1) begin bad++; $display("FAIL lb_rd got=%0d exp=1", m0_rd); end
    drive(32'h13, 32'd0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h00000080) begin bad++; $display("FAIL lbu_alu got=%h exp=%h", m0_alu, 32'h00000080); end
    drive(32'h10, 32'd0, 5'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb got=%h exp=%h", m0_alu, 32'h80ADBEEF); end
    drive(32'h10, 32'd0, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'hFFFFFFEF) begin bad++; $display("FAIL lb_lane0 got=%h exp=%h", m0_alu, 32'hFFFFFFEF); end
    drive(32'h11, 32'd0, 5'd2, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h000000BE) begin bad++; $display("FAIL lbu_lane1 got=%h exp=%h", m0_alu, 32'h000000BE); end
  endtask

  task automatic test_half_misalign();
    drive(32'h22, 32'h00008001, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    drive(32'h22, 32'd0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'hFFFF8001) begin bad++; $display("FAIL lh_alu got=%h exp=%h", m0_alu, 32'hFFFF8001); end
    drive(32'h22, 32'd0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h00008001) begin bad++; $display("FAIL lhu_alu got=%h exp=%h", m0_alu, 32'h00008001); end
    drive(32'h21, 32'd0, 5'd9, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    #1;
    total++; if (m0_stall !== 1'b0) begin bad++; $display("FAIL lh_mis_stall got=%b exp=0", m0_stall); end
    tick();
    total++; if (m0_mis !== 1'b1) begin bad++; $display("FAIL lh_mis_flag got=%b exp=1", m0_mis); end
    total++; if (m0_rd !== 5'd0) begin bad++; $display("FAIL lh_mis_rd got=%0d exp=0", m0_rd); end
    total++; if (m0_alu !== 32'd0) begin bad++; $display("FAIL lh_mis_alu got=%h exp=0", m0_alu); end
    drive(32'h22, 32'h11111111, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    total++; if (m0_mis !== 1'b1) begin bad++; $display("FAIL sw_mis_flag got=%b exp=1", m0_mis); end
    drive(32'h11, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    total++; if (m0_mis !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%b exp=0", m0_mis); end
    drive(32'h22, 32'd0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'hFFFF8001) begin bad++; $display("FAIL lh_unchanged got=%h exp=%h", m0_alu, 32'hFFFF8001); end
    drive(32'h10, 32'd0, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_unchanged got=%h exp=%h", m0_alu, 32'h80ADBEEF); end
  endtask

  task automatic test_bnowb();
    drive(32'h10, 32'd0, 5'd7, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    tick();
    total++; if (m0_rd !== 5'd0) begin bad++; $display("FAIL nowb_lw_rd got=%0d exp=0", m0_rd); end
    total++; if (m0_alu !== 32'h80ADBEEF) begin bad++; $display("FAIL nowb_lw_alu got=%h exp=%h", m0_alu, 32'h80ADBEEF); end
    drive(32'h1234, 32'd0, 5'd3, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m0_stall !== 1'b0) begin bad++; $display("FAIL pass_stall got=%b exp=0", m0_stall); end
    tick();
    total++; if (m0_alu !== 32'h1234) begin bad++; $display("FAIL pass_alu got=%h exp=%h", m0_alu, 32'h1234); end
    total++; if (m0_rd !== 5'd3) begin bad++; $display("FAIL pass_rd got=%0d exp=3", m0_rd); end
    drive(32'h10, 32'h00000055, 5'd6, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    drive(32'h10, 32'd0, 5'd4, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h80ADBE55) begin bad++; $display("FAIL ldst_alu got=%h exp=%h", m0_alu, 32'h80ADBE55); end
    total++; if (m0_rd !== 5'd4) begin bad++; $display("FAIL ldst_rd got=%0d exp=4", m0_rd); end
    drive(32'h10, 32'd0, 5'd4, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    tick();
    total++; if (m0_alu !== 32'h80ADBE55) begin bad++; $display("FAIL sz11_lw got=%h exp=%h", m0_alu, 32'h80ADBE55); end
  endtask

  task automatic test_latency();
    rst = 1'b0;
    idle();
    #2;
    rst = 1'b1;
    tick();
    drive(32'h40, 32'hCAFEF00D, 5'd6, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL sw3_stall_t got=%b exp=1", m3_stall); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL sw3_stall_busy k=%0d got=%b exp=1", k, m3_stall); end
    end
    tick();
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL sw3_stall_done got=%b exp=0", m3_stall); end
    tick();
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL sw3_rd got=%0d exp=0", m3_rd); end
    drive(32'h40, 32'd0, 5'd5, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL lw3_stall_t got=%b exp=1", m3_stall); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL lw3_stall_busy k=%0d got=%b exp=1", k, m3_stall); end
      total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL lw3_bubble k=%0d got=%0d exp=0", k, m3_rd); end
    end
    tick();
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL lw3_stall_done got=%b exp=0", m3_stall); end
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL lw3_bubble3 got=%0d exp=0", m3_rd); end
    tick();
    total++; if (m3_alu !== 32'hCAFEF00D) begin bad++; $display("FAIL lw3_alu got=%h exp=%h", m3_alu, 32'hCAFEF00D); end
    total++; if (m3_rd !== 5'd5) begin bad++; $display("FAIL lw3_rd got=%0d exp=5", m3_rd); end
    drive(32'h77, 32'd0, 5'd2, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL pass3_stall got=%b exp=0", m3_stall); end
    tick();
    total++; if (m3_alu !== 32'h77) begin bad++; $display("FAIL pass3_alu got=%h exp=%h", m3_alu, 32'h77); end
    total++; if (m3_rd !== 5'd2) begin bad++; $display("FAIL pass3_rd got=%0d exp=2", m3_rd); end
    drive(32'h41, 32'd0, 5'd4, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL mis3_stall got=%b exp=0", m3_stall); end
    tick();
    total++; if (m3_mis !== 1'b1) begin bad++; $display("FAIL mis3_flag got=%b exp=1", m3_mis); end
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL mis3_rd got=%0d exp=0", m3_rd); end
    idle();
    tick();
    total++; if (m3_mis !== 1'b0) begin bad++; $display("FAIL mis3_pulse_end got=%b exp=0", m3_mis); end
  endtask

  task automatic test_back_to_back();
    drive(32'h40, 32'd0, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    total++; if (m3_rd !== 5'd1) begin bad++; $display("FAIL b2b_lw_rd got=%0d exp=1", m3_rd); end
    drive(32'h41, 32'h000000AA, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", m3_stall); end
    tick();
    total++; if (m3_alu !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", m3_alu, 32'hCAFEF00D); end
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL b2b_bubble got=%0d exp=0", m3_rd); end
    tick(); tick(); tick();
    drive(32'h40, 32'd0, 5'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    total++; if (m3_stall !== 1'b1) begin bad++; $display("FAIL b2b_accept2 got=%b exp=1", m3_stall); end
    tick(); tick(); tick(); tick();
    total++; if (m3_alu !== 32'hCAFEAA0D) begin bad++; $display("FAIL b2b_lw2_alu got=%h exp=%h", m3_alu, 32'hCAFEAA0D); end
    total++; if (m3_rd !== 5'd2) begin bad++; $display("FAIL b2b_lw2_rd got=%0d exp=2", m3_rd); end
  endtask

  task automatic test_reset_mid();
    drive(32'h40, 32'h12345678, 5'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (m3_stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", m3_stall); end
    total++; if (m3_alu !== 32'd0) begin bad++; $display("FAIL rstmid_alu got=%h exp=0", m3_alu); end
    total++; if (m3_rd !== 5'd0) begin bad++; $display("FAIL rstmid_rd got=%0d exp=0", m3_rd); end
    idle();
    #1;
    rst = 1'b1;
    tick();
    drive(32'h40, 32'd0, 5'd3, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    total++; if (m3_alu !== 32'hCAFEAA0D) begin bad++; $display("FAIL rstmid_nowrite got=%h exp=%h", m3_alu, 32'hCAFEAA0D); end
    total++; if (m3_rd !== 5'd3) begin bad++; $display("FAIL rstmid_lw_rd got=%0d exp=3", m3_rd); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_word();
    test_byte();
    test_half_misalign();
    test_bnowb();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end

endmodule
